// File: rtl/maze_carver_if.sv
// Handshake and cell-write bus between the maze generator and its controller/display.
interface maze_carver_if;
    logic        start;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [3:0]  wr_row;
    logic [3:0]  wr_col;
    logic        wr_wall;

    modport master (
        output start, seed,
        input  busy, done, wr_en, wr_row, wr_col, wr_wall
    );

    modport slave (
        input  start, seed,
        output busy, done, wr_en, wr_row, wr_col, wr_wall
    );
endinterface

// File: rtl/maze_carver.sv
// Recursive-backtracker maze generator: walls a 16x16 cell map, then carves a
// perfect maze over the 7x7 room lattice, streaming one cell write per cycle.
module maze_carver (
    input  logic          clk,
    input  logic          rst,
    maze_carver_if.slave  bus
);
    localparam int unsigned GRID      = 16;
    localparam int unsigned ROOMS     = 7;
    localparam int unsigned ROOM_CNT  = ROOMS * ROOMS;
    localparam logic [15:0] SEED_DFLT = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_INIT, S_PICK, S_WALL, S_ROOM, S_DONE
    } state_t;

    // Rooms are carried as {row[2:0], col[2:0]}; visited bits use row*ROOMS+col.
    function automatic logic [5:0] room_idx(input logic [5:0] room);
        return ({3'b000, room[5:3]} * 6'(ROOMS)) + {3'b000, room[2:0]};
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          clr_cnt_q, clr_cnt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [ROOM_CNT-1:0] visited_q, visited_d;
    logic [5:0]          sp_q, sp_d;
    logic [5:0]          target_q, target_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_en_q, wr_en_d;
    logic [3:0]          wr_row_q, wr_row_d;
    logic [3:0]          wr_col_q, wr_col_d;
    logic                wr_wall_q, wr_wall_d;

    logic [5:0]          stack_q [ROOM_CNT];
    logic                push_c;
    logic [5:0]          push_val_c;

    logic [5:0]          top_c;
    logic [2:0]          tr_c, tc_c;
    logic [3:0]          cand_ok_c;
    logic [5:0]          cand_room_c [4];
    logic                found_c;
    logic [5:0]          pick_c;

    // Neighbour candidates of the top-of-stack room, indexed N,E,S,W.
    always_comb begin
        top_c = stack_q[sp_q - 6'd1];
        tr_c  = top_c[5:3];
        tc_c  = top_c[2:0];
        cand_room_c[0] = {tr_c - 3'd1, tc_c};
        cand_room_c[1] = {tr_c, tc_c + 3'd1};
        cand_room_c[2] = {tr_c + 3'd1, tc_c};
        cand_room_c[3] = {tr_c, tc_c - 3'd1};
        cand_ok_c[0] = (tr_c != 3'd0)             && !visited_q[room_idx(cand_room_c[0])];
        cand_ok_c[1] = (tc_c != 3'(ROOMS - 1))    && !visited_q[room_idx(cand_room_c[1])];
        cand_ok_c[2] = (tr_c != 3'(ROOMS - 1))    && !visited_q[room_idx(cand_room_c[2])];
        cand_ok_c[3] = (tc_c != 3'd0)             && !visited_q[room_idx(cand_room_c[3])];
    end

    // Clockwise scan starting from the LFSR-chosen direction.
    always_comb begin
        logic [1:0] dir;
        found_c = 1'b0;
        pick_c  = '0;
        dir     = '0;
        for (int i = 0; i < 4; i++) begin
            dir = lfsr_q[1:0] + 2'(i);
            if (!found_c && cand_ok_c[dir]) begin
                found_c = 1'b1;
                pick_c  = cand_room_c[dir];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        lfsr_d     = lfsr_q;
        visited_d  = visited_q;
        sp_d       = sp_q;
        target_d   = target_q;
        busy_d     = busy_q;
        done_d     = done_q;
        wr_en_d    = 1'b0;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_wall_d  = wr_wall_q;
        push_c     = 1'b0;
        push_val_c = target_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_CLEAR;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    lfsr_d    = (bus.seed != 16'd0) ? bus.seed : SEED_DFLT;
                    visited_d = '0;
                    sp_d      = '0;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_row_d  = clr_cnt_q[7:4];
                wr_col_d  = clr_cnt_q[3:0];
                wr_wall_d = 1'b1;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'(GRID * GRID - 1)) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                wr_en_d      = 1'b1;
                wr_row_d     = 4'd1;
                wr_col_d     = 4'd1;
                wr_wall_d    = 1'b0;
                visited_d[0] = 1'b1;
                push_c       = 1'b1;
                push_val_c   = '0;
                sp_d         = 6'd1;
                state_d      = S_PICK;
            end
            S_PICK: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                if (found_c) begin
                    target_d = pick_c;
                    state_d  = S_WALL;
                end else begin
                    sp_d = sp_q - 6'd1;
                    if (sp_q == 6'd1) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WALL: begin
                wr_en_d   = 1'b1;
                wr_row_d  = 4'(tr_c) + 4'(target_q[5:3]) + 4'd1;
                wr_col_d  = 4'(tc_c) + 4'(target_q[2:0]) + 4'd1;
                wr_wall_d = 1'b0;
                state_d   = S_ROOM;
            end
            S_ROOM: begin
                wr_en_d   = 1'b1;
                wr_row_d  = {target_q[5:3], 1'b1};
                wr_col_d  = {target_q[2:0], 1'b1};
                wr_wall_d = 1'b0;
                visited_d[room_idx(target_q)] = 1'b1;
                push_c    = 1'b1;
                sp_d      = sp_q + 6'd1;
                state_d   = S_PICK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            lfsr_q    <= SEED_DFLT;
            visited_q <= '0;
            sp_q      <= '0;
            target_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_wall_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            lfsr_q    <= lfsr_d;
            visited_q <= visited_d;
            sp_q      <= sp_d;
            target_q  <= target_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_wall_q <= wr_wall_d;
        end
    end

    // Backtrack stack storage; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            stack_q[sp_q] <= push_val_c;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_row  = wr_row_q;
    assign bus.wr_col  = wr_col_q;
    assign bus.wr_wall = wr_wall_q;
endmodule

// File: tb/tb_maze_carver.sv
// Self-checking bench: maze runs compared against a loop-level backtracker model,
// plus structural checks on the resulting map and reset/restart sequences.
module tb_maze_carver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maze_carver_if bus ();
    maze_carver dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [8:0] prev_q[$];
    int         exp_cycles;

    typedef struct {
        logic [15:0] seed;
        int          ign1;
        int          ign2;
        int          cmp_prev;   // 0 none, 1 must equal previous run, 2 must differ
        int          exp_busy;
        int          exp_writes;
        int          exp_open;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backtracker written straight from the generation rules.
    task automatic model_run(input logic [15:0] seed);
        bit          vis[7][7];
        int          sr[49];
        int          sc[49];
        int          dr[4];
        int          dc[4];
        int          sp, r, c, nr, nc, d0, d;
        bit          found;
        logic [15:0] l;
        dr = '{-1, 0, 1, 0};
        dc = '{0, 1, 0, -1};
        for (int i = 0; i < 7; i++) for (int j = 0; j < 7; j++) vis[i][j] = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back({4'(i / 16), 4'(i % 16), 1'b1});
        l = (seed == 16'd0) ? 16'hACE1 : seed;
        exp_q.push_back({4'd1, 4'd1, 1'b0});
        vis[0][0] = 1'b1; sr[0] = 0; sc[0] = 0; sp = 1;
        exp_cycles = 257;
        nr = 0; nc = 0;
        while (sp > 0) begin
            r  = sr[sp-1];
            c  = sc[sp-1];
            d0 = int'(l[1:0]);
            l  = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            exp_cycles++;
            found = 1'b0;
            for (int i = 0; i < 4 && !found; i++) begin
                d  = (d0 + i) % 4;
                nr = r + dr[d];
                nc = c + dc[d];
                if (nr >= 0 && nr < 7 && nc >= 0 && nc < 7)
                    if (!vis[nr][nc]) found = 1'b1;
            end
            if (found) begin
                exp_q.push_back({4'(r + nr + 1), 4'(c + nc + 1), 1'b0});
                exp_q.push_back({4'(2 * nr + 1), 4'(2 * nc + 1), 1'b0});
                vis[nr][nc] = 1'b1;
                sr[sp] = nr; sc[sp] = nc; sp++;
                exp_cycles += 2;
            end else begin
                sp--;
            end
        end
    endtask

    function automatic int stream_diff(input logic [8:0] a[$], input logic [8:0] b[$]);
        int n = 0;
        int lim = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < lim; i++) if (a[i] !== b[i]) n++;
        return n + ((a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size());
    endfunction

    // Start a run, pulse stray starts at ign1/ign2, and capture the write stream.
    task automatic run_dut(input logic [15:0] seed, input int ign1, input int ign2,
                           output int busy_cnt);
        got_q.delete();
        busy_cnt = 0;
        bus.seed  = seed;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("accept_busy", 32'(bus.busy), 1);
        check("accept_done", 32'(bus.done), 0);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            if (bus.wr_en) got_q.push_back({bus.wr_row, bus.wr_col, bus.wr_wall});
            if (cyc == ign1 || cyc == ign2) begin
                bus.start = 1'b1;
                bus.seed  = ~seed;
            end else begin
                bus.start = 1'b0;
                bus.seed  = seed;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("done_seen", 32'(bus.done), 1);
        check("busy_low_at_done", 32'(bus.busy), 0);
        @(posedge clk); #1;
        check("done_hold", 32'({bus.done, bus.busy, bus.wr_en}), 32'b100);
    endtask

    // Shadow-map structure checks on the captured stream.
    task automatic analyze(input int exp_open);
        int m[16][16];
        bit seen[16][16];
        int q[$];
        int dr[4];
        int dc[4];
        int open, rooms, reach, adj, bad, unk, p, r, c, nr, nc;
        dr = '{-1, 0, 1, 0};
        dc = '{0, 1, 0, -1};
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
            m[i][j] = 2; seen[i][j] = 1'b0;
        end
        foreach (got_q[i]) m[got_q[i][8:5]][got_q[i][4:1]] = int'(got_q[i][0]);
        open = 0; rooms = 0; adj = 0; bad = 0; unk = 0; reach = 0;
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
            if (m[i][j] == 2) unk++;
            if (m[i][j] == 0) begin
                open++;
                if (j < 15 && m[i][j+1] == 0) adj++;
                if (i < 15 && m[i+1][j] == 0) adj++;
                if (i == 0 || i >= 14 || j == 0 || j >= 14 || (i % 2 == 0 && j % 2 == 0)) bad++;
            end
            if (i % 2 == 1 && j % 2 == 1 && i < 14 && j < 14 && m[i][j] == 0) rooms++;
        end
        if (m[1][1] == 0) begin
            q.push_back(17); seen[1][1] = 1'b1;
        end
        while (q.size() > 0) begin
            p = q.pop_front(); reach++;
            r = p / 16; c = p % 16;
            for (int k = 0; k < 4; k++) begin
                nr = r + dr[k]; nc = c + dc[k];
                if (nr >= 0 && nr < 16 && nc >= 0 && nc < 16)
                    if (m[nr][nc] == 0 && !seen[nr][nc]) begin
                        seen[nr][nc] = 1'b1;
                        q.push_back(nr * 16 + nc);
                    end
            end
        end
        check("map_unknown", 32'(unk), 0);
        check("open_cells", 32'(open), 32'(exp_open));
        check("rooms_open", 32'(rooms), 49);
        check("flood_reach", 32'(reach), 32'(open));
        check("adjacencies", 32'(adj), 32'(open - 1));
        check("forbidden_open", 32'(bad), 0);
    endtask

    task automatic full_run(input vec_t v);
        int busy_cnt;
        int dif;
        logic [8:0] w257;
        model_run(v.seed);
        run_dut(v.seed, v.ign1, v.ign2, busy_cnt);
        check("busy_cycles", 32'(busy_cnt), 32'(v.exp_busy));
        check("busy_vs_model", 32'(busy_cnt), 32'(exp_cycles));
        check("write_count", 32'(got_q.size()), 32'(v.exp_writes));
        check("stream_vs_model", 32'(stream_diff(got_q, exp_q)), 0);
        check("first_write", 32'((got_q.size() > 0) ? got_q[0] : 9'h1FE), 32'(9'b0000_0000_1));
        w257 = (got_q.size() > 256) ? got_q[256] : 9'h1FF;
        check("write_257", 32'(w257), 32'({4'd1, 4'd1, 1'b0}));
        analyze(v.exp_open);
        dif = stream_diff(got_q, prev_q);
        if (v.cmp_prev == 1) check("repeat_identical", 32'(dif), 0);
        if (v.cmp_prev == 2) check("seed_differs", 32'(dif != 0), 1);
        prev_q = got_q;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h0000, -1, -1, 0, 450, 353, 97};
        vecs[1] = '{16'h1234, -1, -1, 0, 450, 353, 97};
        vecs[2] = '{16'h1234, -1, -1, 1, 450, 353, 97};
        vecs[3] = '{16'h0001, -1, -1, 2, 450, 353, 97};
        vecs[4] = '{16'($urandom()), 100, 300, 0, 450, 353, 97};
        vecs[5] = '{16'($urandom()), 5, 448, 0, 450, 353, 97};
        vecs[6] = '{16'($urandom()), -1, -1, 0, 450, 353, 97};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.seed  = 16'd0;
        #1;
        check("reset_async", 32'({bus.busy, bus.done, bus.wr_en}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_wr_en", 32'(bus.wr_en), 0);
        check("reset_wr_addr", 32'({bus.wr_row, bus.wr_col, bus.wr_wall}), 0);
        @(posedge clk); #1;
        check("idle_no_write", 32'({bus.busy, bus.wr_en}), 0);

        foreach (vecs[i]) full_run(vecs[i]);

        // Reset during the carve phase, then a clean rerun.
        bus.seed  = 16'h5A5A;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (269) begin @(posedge clk); #1; end
        check("pre_reset_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("midrun_reset", 32'({bus.busy, bus.wr_en, bus.done}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_reset_idle", 32'({bus.busy, bus.done, bus.wr_en}), 0);
        full_run('{16'h5A5A, -1, -1, 0, 450, 353, 97});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
